load_store_unit: RTL and testbench

Per-thread load/store unit for the miniGPU core. It executes LDR/STR for one thread lane, taking the address from `rs_data` and the store data from `rt_data`, both sourced from that lane's RegisterFile. It runs a valid/ready handshake toward the memory controller, and returns the loaded byte on `lsu_out`. The RegisterFile selects `lsu_out` through its memory input-mux path during UPDATE.

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 111 +++++++++++
 tb/tb_load_store_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - memory-controller handshake bundle for one lane's load/store unit
interface load_store_unit_if;
    logic       mem_read_valid;
    logic [7:0] mem_read_address;
    logic       mem_read_ready;
    logic [7:0] mem_read_data;
    logic       mem_write_valid;
    logic [7:0] mem_write_address;
    logic [7:0] mem_write_data;
    logic       mem_write_ready;

    // Load/store unit side: issues requests, receives completions.
    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data,
        output mem_write_valid,
        output mem_write_address,
        output mem_write_data,
        input  mem_write_ready
    );

    // Memory controller side.
    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data,
        input  mem_write_valid,
        input  mem_write_address,
        input  mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - per-thread LDR/STR unit with valid/ready handshake and access timeout
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [7:0]           rs_data,
    input  logic [7:0]           rt_data,
    load_store_unit_if.master    mem,
    output logic [1:0]           lsu_state,
    output logic [7:0]           lsu_out,
    output logic                 mem_error
);
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUESTING = 2'd1,
        WAITING    = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t        state;
    logic          is_read;
    logic [CW-1:0] wait_count;

    assign lsu_state = state;

    // Access sequencer: every output is a register written only here, and a
    // disabled lane freezes the whole unit, including the wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            is_read               <= 1'b0;
            wait_count            <= '0;
            mem.mem_read_valid    <= 1'b0;
            mem.mem_read_address  <= 8'h00;
            mem.mem_write_valid   <= 1'b0;
            mem.mem_write_address <= 8'h00;
            mem.mem_write_data    <= 8'h00;
            lsu_out               <= 8'h00;
            mem_error             <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    // Read wins when the decoder flags both.
                    if (core_state == CORE_REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        is_read <= decoded_mem_read_enable;
                        state   <= REQUESTING;
                    end
                end
                REQUESTING: begin
                    wait_count <= '0;
                    if (is_read) begin
                        mem.mem_read_address <= rs_data;
                        mem.mem_read_valid   <= 1'b1;
                    end else begin
                        mem.mem_write_address <= rs_data;
                        mem.mem_write_data    <= rt_data;
                        mem.mem_write_valid   <= 1'b1;
                    end
                    state <= WAITING;
                end
                WAITING: begin
                    if (is_read) begin
                        if (mem.mem_read_ready) begin
                            lsu_out            <= mem.mem_read_data;
                            mem.mem_read_valid <= 1'b0;
                            state              <= DONE;
                        end else if (wait_count == LAST_WAIT) begin
                            lsu_out            <= 8'hFF;
                            mem_error          <= 1'b1;
                            mem.mem_read_valid <= 1'b0;
                            state              <= DONE;
                        end else begin
                            wait_count <= wait_count + 1'b1;
                        end
                    end else begin
                        if (mem.mem_write_ready) begin
                            mem.mem_write_valid <= 1'b0;
                            state               <= DONE;
                        end else if (wait_count == LAST_WAIT) begin
                            mem_error           <= 1'b1;
                            mem.mem_write_valid <= 1'b0;
                            state               <= DONE;
                        end else begin
                            wait_count <= wait_count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // lsu_out is left alone here so UPDATE can capture it.
                    if (core_state == CORE_UPDATE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
    localparam int T = 4;
    localparam logic [2:0] REQ = 3'b011;
    localparam logic [2:0] UPD = 3'b110;
    localparam logic [2:0] EXE = 3'b100;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       rd_en;
    logic       wr_en;
    logic [7:0] rs_data;
    logic [7:0] rt_data;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       mem_error;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .rs_data                  (rs_data),
        .rt_data                  (rt_data),
        .mem                      (bus.master),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out),
        .mem_error                (mem_error)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference state: last loaded byte and sticky error flag.
    logic [7:0] m_out;
    bit         m_err;

    typedef struct {
        bit         rd;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         delay;
        logic [7:0] exp_out;
        bit         exp_err;
        int         exp_vc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access. The memory side asserts ready on the selected port
    // in WAITING cycle number 'delay' (0-based); delays >= T never respond.
    task automatic do_access(input bit rd, input bit wr, input logic [7:0] addr,
                             input logic [7:0] wdata, input logic [7:0] rdata,
                             input int delay, input logic [7:0] exp_out,
                             input bit exp_err, input int exp_vc, input string tag);
        int  vc;
        int  edges;
        int  k;
        bit  done;
        bit  sel_rd;
        sel_rd     = rd;
        enable     = 1'b1;
        rd_en      = rd;
        wr_en      = wr;
        rs_data    = addr;
        rt_data    = wdata;
        core_state = REQ;
        tick();
        core_state = EXE;
        chk({tag, "_requesting"}, 32'(lsu_state), 32'd1);
        edges = 1;
        vc    = 0;
        k     = 0;
        done  = 0;
        while (!done && edges < 40) begin
            tick();
            edges++;
            if (lsu_state == 2'd2) begin
                vc++;
                if (sel_rd) begin
                    chk({tag, "_rvalid"}, 32'(bus.mem_read_valid), 32'd1);
                    chk({tag, "_wvalid_off"}, 32'(bus.mem_write_valid), 32'd0);
                    chk({tag, "_raddr"}, 32'(bus.mem_read_address), 32'(addr));
                    bus.mem_read_ready  = (k == delay);
                    bus.mem_read_data   = (k == delay) ? rdata : 8'($urandom);
                    bus.mem_write_ready = 1'($urandom);
                end else begin
                    chk({tag, "_wvalid"}, 32'(bus.mem_write_valid), 32'd1);
                    chk({tag, "_rvalid_off"}, 32'(bus.mem_read_valid), 32'd0);
                    chk({tag, "_waddr"}, 32'(bus.mem_write_address), 32'(addr));
                    chk({tag, "_wdata"}, 32'(bus.mem_write_data), 32'(wdata));
                    bus.mem_write_ready = (k == delay);
                    bus.mem_read_ready  = 1'($urandom);
                    bus.mem_read_data   = 8'($urandom);
                end
                k++;
            end else begin
                bus.mem_read_ready  = 1'b0;
                bus.mem_write_ready = 1'b0;
                if (lsu_state == 2'd3) done = 1;
            end
        end
        bus.mem_read_ready  = 1'b0;
        bus.mem_write_ready = 1'b0;
        if (!done) chk({tag, "_reached_done"}, 32'd0, 32'd1);
        chk({tag, "_valid_cycles"}, 32'(vc), 32'(exp_vc));
        chk({tag, "_edges_to_done"}, 32'(edges), 32'(exp_vc + 2));
        chk({tag, "_valids_low"}, {30'd0, bus.mem_read_valid, bus.mem_write_valid}, 32'd0);
        chk({tag, "_lsu_out"}, 32'(lsu_out), 32'(exp_out));
        chk({tag, "_mem_error"}, 32'(mem_error), 32'(exp_err));
        // Ready in DONE must be ignored.
        bus.mem_read_ready  = 1'b1;
        bus.mem_write_ready = 1'b1;
        bus.mem_read_data   = 8'hEE;
        tick();
        bus.mem_read_ready  = 1'b0;
        bus.mem_write_ready = 1'b0;
        chk({tag, "_done_hold"}, 32'(lsu_state), 32'd3);
        chk({tag, "_done_out"}, 32'(lsu_out), 32'(exp_out));
        core_state = UPD;
        tick();
        core_state = EXE;
        chk({tag, "_idle"}, 32'(lsu_state), 32'd0);
        chk({tag, "_out_after_update"}, 32'(lsu_out), 32'(exp_out));
    endtask

    vec_t tbl[6];

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        core_state = 3'b000;
        rd_en = 1'b0;
        wr_en = 1'b0;
        rs_data = 8'h00;
        rt_data = 8'h00;
        bus.mem_read_ready = 1'b0;
        bus.mem_read_data = 8'h00;
        bus.mem_write_ready = 1'b0;

        tick();
        tick();
        reset = 1'b0;
        chk("reset_state", 32'(lsu_state), 32'd0);
        chk("reset_valids", {30'd0, bus.mem_read_valid, bus.mem_write_valid}, 32'd0);
        chk("reset_addrs", {16'd0, bus.mem_read_address, bus.mem_write_address}, 32'd0);
        chk("reset_wdata", 32'(bus.mem_write_data), 32'd0);
        chk("reset_out", 32'(lsu_out), 32'd0);
        chk("reset_err", 32'(mem_error), 32'd0);

        //            rd wr addr   wdata  rdata  dly out    err vc
        tbl[0] = '{1, 0, 8'h10, 8'h00, 8'hDE, 0, 8'hDE, 0, 1};
        tbl[1] = '{0, 1, 8'h22, 8'hA5, 8'h00, 2, 8'hDE, 0, 3};
        tbl[2] = '{1, 1, 8'h33, 8'h77, 8'h5A, 1, 8'h5A, 0, 2};
        tbl[3] = '{1, 0, 8'h44, 8'h00, 8'h00, 9, 8'hFF, 1, 4};
        tbl[4] = '{1, 0, 8'h55, 8'h00, 8'h77, 0, 8'h77, 1, 1};
        tbl[5] = '{0, 1, 8'h66, 8'h3C, 8'h00, 3, 8'h77, 1, 4};
        for (int i = 0; i < 6; i++) begin
            do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                      tbl[i].delay, tbl[i].exp_out, tbl[i].exp_err, tbl[i].exp_vc,
                      $sformatf("vec%0d", i));
        end

        // Reset in the middle of a handshake.
        enable = 1'b1; rd_en = 1'b1; wr_en = 1'b0; rs_data = 8'hC3; core_state = REQ;
        tick();
        core_state = EXE;
        tick();
        chk("rst_mid_valid_before", 32'(bus.mem_read_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_valid", 32'(bus.mem_read_valid), 32'd0);
        chk("rst_mid_state", 32'(lsu_state), 32'd0);
        chk("rst_mid_out", 32'(lsu_out), 32'd0);
        chk("rst_mid_err", 32'(mem_error), 32'd0);
        chk("rst_mid_addr", 32'(bus.mem_read_address), 32'd0);
        m_out = 8'h00;
        m_err = 0;

        // Enable dropped while WAITING, with ready pulsed while disabled.
        rd_en = 1'b1; rs_data = 8'h80; core_state = REQ;
        tick();
        core_state = EXE;
        tick();
        tick();
        chk("en_drop_waiting", 32'(lsu_state), 32'd2);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_read_ready = (i == 1 || i == 2);
            bus.mem_read_data  = 8'h11;
            core_state = UPD;
            tick();
            chk($sformatf("en_drop_state%0d", i), 32'(lsu_state), 32'd2);
            chk($sformatf("en_drop_valid%0d", i), 32'(bus.mem_read_valid), 32'd1);
            chk($sformatf("en_drop_out%0d", i), 32'(lsu_out), 32'd0);
        end
        bus.mem_read_ready = 1'b0;
        core_state = EXE;
        enable = 1'b1;
        tick();
        chk("en_back_waiting", 32'(lsu_state), 32'd2);
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 8'h99;
        tick();
        bus.mem_read_ready = 1'b0;
        chk("en_back_done", 32'(lsu_state), 32'd3);
        chk("en_back_out", 32'(lsu_out), 32'h99);
        chk("en_back_err", 32'(mem_error), 32'd0);
        core_state = UPD;
        tick();
        core_state = EXE;
        chk("en_back_idle", 32'(lsu_state), 32'd0);
        m_out = 8'h99;

        // Neither enable at REQUEST, and REQUEST with the lane disabled.
        rd_en = 1'b0; wr_en = 1'b0; core_state = REQ;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("no_op_idle%0d", i), 32'(lsu_state), 32'd0);
            chk($sformatf("no_op_valid%0d", i),
                {30'd0, bus.mem_read_valid, bus.mem_write_valid}, 32'd0);
        end
        enable = 1'b0; rd_en = 1'b1;
        tick();
        chk("disabled_request_idle", 32'(lsu_state), 32'd0);
        enable = 1'b1; rd_en = 1'b0; core_state = EXE;

        // Randomized accesses against the transaction-level model.
        for (int n = 0; n < 30; n++) begin
            bit         r_rd;
            bit         r_wr;
            int         op;
            int         dly;
            int         vc;
            logic [7:0] a;
            logic [7:0] wd;
            logic [7:0] rdv;
            op  = $urandom_range(0, 2);
            r_rd = (op != 1);
            r_wr = (op != 0);
            dly = $urandom_range(0, 6);
            a   = 8'($urandom);
            wd  = 8'($urandom);
            rdv = 8'($urandom);
            vc  = (dly < T) ? dly + 1 : T;
            if (r_rd) m_out = (dly < T) ? rdv : 8'hFF;
            if (dly >= T) m_err = 1;
            do_access(r_rd, r_wr, a, wd, rdv, dly, m_out, m_err, vc,
                      $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
